tdm_fir_filter: RTL and testbench
=================================

# tdm_fir_filter

Parametrised, time-division-multiplexed FIR filter: the successor to the single-channel, fixed-coefficient filter in the current top-level. It serves N_CH interleaved channels from one shared multiply-accumulate unit, with per-channel delay lines and a run-time loadable coefficient bank. It sits between the signal source and the output probe bus, with a valid/ready handshake on input and a valid strobe on output.

## Interface
- NB_DATA, 8: signed input sample width
- NB_COEF, 8: signed coefficient width, Q1.(NB_COEF-1)
- NB_OUT, 8: signed output width
- N_TAPS, 4: taps per channel, ≥2
- N_CH, 2: channel count, ≥1
- clock  in  1  system clock, rising edge
- i_reset  in  1  asynchronous, active-low reset
- i_sample  in  NB_DATA  input sample
- i_valid  in  1  sample valid
- i_frame  in  1  qualifies i_valid; marks the sample as channel 0
- o_ready  out  1  block can accept a sample
- i_coef_we  in  1  coefficient write strobe
- i_coef_addr  in  clog2(N_TAPS)  tap index
- i_coef_data  in  NB_COEF  coefficient value
- o_coef_drop  out  1  one-cycle pulse: write rejected
- o_data  out  NB_OUT  filtered sample
- o_channel  out  clog2(N_CH) (min 1)  channel of o_data
- o_valid  out  1  one-cycle output strobe

## Operation
- **FSM states:** IDLE, MAC, DONE.
  - IDLE→MAC on accept (i_valid & o_ready).
  - MAC holds for N_TAPS cycles, then →DONE.
  - DONE→MAC on accept, else →IDLE.
- **Handshake:** o_ready = (state==IDLE | state==DONE), decoded from state.
- **Channel select:**
  - On accept, the channel is 0 if i_frame=1, else the internal channel counter.
  - The counter becomes channel+1, wrapping N_CH-1→0.
- **Delay line:** on accept, the selected channel's delay line shifts (new sample at tap 0, oldest discarded). Other channels are untouched.
- **MAC:** tap k = 0..N_TAPS-1 multiplies delay[ch][k] by coef[k]. The accumulator clears on accept.
- **Arithmetic widths:**
  - Product: NB_DATA+NB_COEF bits, signed.
  - Accumulator: NB_DATA+NB_COEF+clog2(N_TAPS) bits. It never overflows.
- **Scaling:** result = acc >>> (NB_COEF-1) (arithmetic shift, floor), then reduced to NB_OUT bits (see Configuration).
- **Coefficient writes:**
  - Accepted only when o_ready=1. They take effect for the next accepted sample.
  - A write while o_ready=0 is dropped, and o_coef_drop pulses the following cycle.
  - A write to addr ≥ N_TAPS is ignored.
- **Reset values:** all coefficients 0, all delay lines 0, channel counter 0, state IDLE, o_ready=1, o_valid=0, o_data=0, o_channel=0, o_coef_drop=0.

## Timing
- **Throughput and latency:** accept at cycle T.
  - MAC runs cycles T+1..T+N_TAPS.
  - o_valid=1 at T+N_TAPS+1, with o_data and o_channel valid for exactly that cycle.
  - o_data and o_channel hold their value until the next output.
  - o_ready is low T+1..T+N_TAPS and high again at T+N_TAPS+1.
  - Maximum rate is one sample per N_TAPS+1 cycles.
- **Input after a drop:** i_valid while o_ready=0 is not accepted. The source holds the sample.
- **Reset mid-operation:** asynchronous assertion aborts any MAC. No o_valid is produced for the aborted sample, and all state returns to its reset value immediately.
- **Simultaneous events:** a coefficient write and a sample accept in the same cycle are both performed. The new coefficient is used by that sample's MAC.

## Configuration
- FIR_SAT_EN defined: the scaled result saturates to [-2^(NB_OUT-1), 2^(NB_OUT-1)-1].
- FIR_SAT_EN undefined: the scaled result is truncated to its low NB_OUT bits (two's-complement wrap).

## Structure
- **Package `fir_pkg`:**
  - FSM state typedef/encoding
  - default widths
  - clog2 helper function
  - derived accumulator-width constant
- **Sub-module `fir_mac`:**
  - signed multiply-accumulate with synchronous clear and enable
  - async active-low reset
  - parametrised by NB_DATA, NB_COEF and accumulator width
- The FSM, delay-line RAM, coefficient bank and output stage live in tdm_fir_filter.

## Test plan
All scenarios use the default parameters.
- **Reset:** hold i_reset=0 for 5 cycles → o_valid=0, o_data=0, o_ready=1, o_channel=0.
- **Impulse:**
  - Stimulus: load coefs {64,32,16,8}; feed ch0 sample 100 then 0,0,0 on ch0, with 0 on ch1 interleaved.
  - Response: ch0 outputs 50,25,12,6; ch1 outputs all 0; each o_valid comes 5 cycles after its accept.
- **Overflow:**
  - Stimulus: all coefs 127; four ch0 samples of 127.
  - 4th output with FIR_SAT_EN: 127.
  - 4th output without FIR_SAT_EN: -8 (504 wrapped).
- **Dropped write:** coef write issued 2 cycles after an accept → o_coef_drop pulses once, the coefficient bank is unchanged, and the next output uses the old coefficients.
- **Mid-MAC reset:** assert i_reset low at T+2 → no o_valid; after release, impulse 100 on ch0 yields 50, proving the delay lines were cleared.
- **Streaming with frame realign:**
  - i_valid held high → accepts every 5 cycles, o_channel alternates 0,1,0,1.
  - i_frame=1 on an accept where the counter is 1 → that output has o_channel=0 and the next has o_channel=1.

Source files
------------

// File: rtl/tdm_fir_filter_pkg.sv
// Shared types and width helpers for the TDM FIR filter.
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } fir_state_t;

  localparam int unsigned NB_DATA_DEF = 8;
  localparam int unsigned NB_COEF_DEF = 8;
  localparam int unsigned NB_OUT_DEF  = 8;
  localparam int unsigned N_TAPS_DEF  = 4;
  localparam int unsigned N_CH_DEF    = 2;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Channel index is at least one bit wide even for a single channel.
  function automatic int unsigned ch_width(input int unsigned n_ch);
    return (clog2(n_ch) < 1) ? 1 : clog2(n_ch);
  endfunction

  function automatic int unsigned acc_width(input int unsigned nb_data,
                                            input int unsigned nb_coef,
                                            input int unsigned n_taps);
    return nb_data + nb_coef + clog2(n_taps);
  endfunction

  localparam int unsigned NB_ACC_DEF = acc_width(NB_DATA_DEF, NB_COEF_DEF, N_TAPS_DEF);

endpackage

// File: rtl/tdm_fir_filter_if.sv
// Sample/coefficient/output bus of the TDM FIR filter.
interface tdm_fir_filter_if
  import fir_pkg::*;
#(
  parameter int unsigned NB_DATA = NB_DATA_DEF,
  parameter int unsigned NB_COEF = NB_COEF_DEF,
  parameter int unsigned NB_OUT  = NB_OUT_DEF,
  parameter int unsigned N_TAPS  = N_TAPS_DEF,
  parameter int unsigned N_CH    = N_CH_DEF
);
  localparam int unsigned NB_ADDR = clog2(N_TAPS);
  localparam int unsigned NB_CH   = ch_width(N_CH);

  logic signed [NB_DATA-1:0] i_sample;
  logic                      i_valid;
  logic                      i_frame;
  logic                      o_ready;
  logic                      i_coef_we;
  logic        [NB_ADDR-1:0] i_coef_addr;
  logic signed [NB_COEF-1:0] i_coef_data;
  logic                      o_coef_drop;
  logic signed [NB_OUT-1:0]  o_data;
  logic        [NB_CH-1:0]   o_channel;
  logic                      o_valid;

  modport master (
    output i_sample, i_valid, i_frame, i_coef_we, i_coef_addr, i_coef_data,
    input  o_ready, o_coef_drop, o_data, o_channel, o_valid
  );

  modport slave (
    input  i_sample, i_valid, i_frame, i_coef_we, i_coef_addr, i_coef_data,
    output o_ready, o_coef_drop, o_data, o_channel, o_valid
  );

endinterface

// File: rtl/tdm_fir_filter_mac.sv
// Signed multiply-accumulate; o_sum is the accumulator plus the current product.
module fir_mac #(
  parameter int unsigned NB_DATA = 8,
  parameter int unsigned NB_COEF = 8,
  parameter int unsigned NB_ACC  = 18
) (
  input  logic                      clock,
  input  logic                      i_reset,
  input  logic                      i_clear,
  input  logic                      i_en,
  input  logic signed [NB_DATA-1:0] i_data,
  input  logic signed [NB_COEF-1:0] i_coef,
  output logic signed [NB_ACC-1:0]  o_sum
);
  localparam int unsigned NB_PROD = NB_DATA + NB_COEF;

  logic signed [NB_PROD-1:0] prod;
  logic signed [NB_ACC-1:0]  acc;

  assign prod  = NB_PROD'(i_data) * NB_PROD'(i_coef);
  assign o_sum = acc + NB_ACC'(prod);

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset)     acc <= '0;
    else if (i_clear) acc <= '0;
    else if (i_en)    acc <= o_sum;
  end

endmodule

// File: rtl/tdm_fir_filter.sv
// Time-multiplexed N_CH-channel FIR with a shared MAC and loadable coefficients.
// Define FIR_SAT_EN to saturate the scaled result instead of wrapping it.
module tdm_fir_filter
  import fir_pkg::*;
#(
  parameter int unsigned NB_DATA = NB_DATA_DEF,
  parameter int unsigned NB_COEF = NB_COEF_DEF,
  parameter int unsigned NB_OUT  = NB_OUT_DEF,
  parameter int unsigned N_TAPS  = N_TAPS_DEF,
  parameter int unsigned N_CH    = N_CH_DEF
) (
  input  logic             clock,
  input  logic             i_reset,
  tdm_fir_filter_if.slave  bus
);
  localparam int unsigned NB_ADDR = clog2(N_TAPS);
  localparam int unsigned NB_CH   = ch_width(N_CH);
  localparam int unsigned NB_ACC  = acc_width(NB_DATA, NB_COEF, N_TAPS);

  fir_state_t state;
  logic [NB_ADDR-1:0] tap;
  logic [NB_CH-1:0]   cur_ch;
  logic [NB_CH-1:0]   ch_cnt;
  logic [NB_CH-1:0]   sel_ch;
  logic [NB_CH-1:0]   next_ch;
  logic               ready;
  logic               accept;
  logic               valid_q;
  logic               drop_q;
  logic signed [NB_OUT-1:0] data_q;
  logic [NB_CH-1:0]         channel_q;

  logic signed [NB_DATA-1:0] dly  [N_CH][N_TAPS];
  logic signed [NB_COEF-1:0] coef [N_TAPS];

  logic signed [NB_ACC-1:0] sum;
  logic signed [NB_OUT-1:0] result;

  assign ready   = (state == IDLE) || (state == DONE);
  assign accept  = bus.i_valid && ready;
  assign sel_ch  = bus.i_frame ? '0 : ch_cnt;
  assign next_ch = (sel_ch == NB_CH'(N_CH - 1)) ? '0 : sel_ch + NB_CH'(1);

  assign bus.o_ready     = ready;
  assign bus.o_valid     = valid_q;
  assign bus.o_data      = data_q;
  assign bus.o_channel   = channel_q;
  assign bus.o_coef_drop = drop_q;

  fir_mac #(
    .NB_DATA (NB_DATA),
    .NB_COEF (NB_COEF),
    .NB_ACC  (NB_ACC)
  ) u_mac (
    .clock   (clock),
    .i_reset (i_reset),
    .i_clear (accept),
    .i_en    (state == MAC),
    .i_data  (dly[cur_ch][tap]),
    .i_coef  (coef[tap]),
    .o_sum   (sum)
  );

`ifdef FIR_SAT_EN
  localparam logic signed [NB_ACC-1:0] OUT_MAX = {{(NB_ACC-NB_OUT+1){1'b0}}, {(NB_OUT-1){1'b1}}};
  localparam logic signed [NB_ACC-1:0] OUT_MIN = {{(NB_ACC-NB_OUT+1){1'b1}}, {(NB_OUT-1){1'b0}}};
  logic signed [NB_ACC-1:0] shifted;

  always_comb begin
    shifted = sum >>> (NB_COEF - 1);
    if (shifted > OUT_MAX)      result = OUT_MAX[NB_OUT-1:0];
    else if (shifted < OUT_MIN) result = OUT_MIN[NB_OUT-1:0];
    else                        result = shifted[NB_OUT-1:0];
  end
`else
  always_comb begin
    result = NB_OUT'(sum >>> (NB_COEF - 1));
  end
`endif

  // Coefficient bank and per-channel delay lines; a write coinciding with an
  // accept lands before the first MAC cycle, so that sample already uses it.
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      for (int unsigned c = 0; c < N_CH; c++)
        for (int unsigned k = 0; k < N_TAPS; k++)
          dly[c][k] <= '0;
      for (int unsigned k = 0; k < N_TAPS; k++)
        coef[k] <= '0;
    end else begin
      if (bus.i_coef_we && ready && (32'(bus.i_coef_addr) < N_TAPS))
        coef[bus.i_coef_addr] <= bus.i_coef_data;
      if (accept) begin
        dly[sel_ch][0] <= bus.i_sample;
        for (int unsigned k = 1; k < N_TAPS; k++)
          dly[sel_ch][k] <= dly[sel_ch][k-1];
      end
    end
  end

  // The last tap's product is folded in through sum, so the output registers
  // on the same edge that leaves MAC.
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      state     <= IDLE;
      tap       <= '0;
      cur_ch    <= '0;
      ch_cnt    <= '0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      channel_q <= '0;
      drop_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      drop_q  <= bus.i_coef_we && !ready;
      unique case (state)
        IDLE, DONE: begin
          if (accept) begin
            state  <= MAC;
            tap    <= '0;
            cur_ch <= sel_ch;
            ch_cnt <= next_ch;
          end else begin
            state <= IDLE;
          end
        end
        MAC: begin
          if (tap == NB_ADDR'(N_TAPS - 1)) begin
            state     <= DONE;
            valid_q   <= 1'b1;
            data_q    <= result;
            channel_q <= cur_ch;
          end else begin
            tap <= tap + NB_ADDR'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tdm_fir_filter.sv
// Directed self-checking bench for tdm_fir_filter (default parameters).
module tb_tdm_fir_filter;
  import fir_pkg::*;

  localparam int unsigned NB_DATA = 8;
  localparam int unsigned NB_COEF = 8;
  localparam int unsigned NB_OUT  = 8;
  localparam int unsigned N_TAPS  = 4;
  localparam int unsigned N_CH    = 2;
  localparam int unsigned NB_ADDR = clog2(N_TAPS);

`ifdef FIR_SAT_EN
  localparam int OVF_EXP = 127;
`else
  localparam int OVF_EXP = -8;
`endif

  logic clock   = 1'b0;
  logic i_reset = 1'b0;
  always #5 clock = ~clock;

  tdm_fir_filter_if #(
    .NB_DATA (NB_DATA), .NB_COEF (NB_COEF), .NB_OUT (NB_OUT),
    .N_TAPS  (N_TAPS),  .N_CH    (N_CH)
  ) bus ();

  tdm_fir_filter #(
    .NB_DATA (NB_DATA), .NB_COEF (NB_COEF), .NB_OUT (NB_OUT),
    .N_TAPS  (N_TAPS),  .N_CH    (N_CH)
  ) dut (
    .clock   (clock),
    .i_reset (i_reset),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int q_data[$];
  int q_ch[$];
  int q_cyc[$];

  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    forever begin
      @(negedge clock);
      if (bus.o_valid === 1'b1) begin
        q_data.push_back(int'(bus.o_data));
        q_ch.push_back(int'(bus.o_channel));
        q_cyc.push_back(cyc);
      end
    end
  end

  task automatic check(input string tag, input int observed, input int expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    @(negedge clock);
    while (bus.o_ready !== 1'b1 && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (n >= 50) check({tag, "_ready_timeout"}, 0, 1);
  endtask

  task automatic write_coef(input int addr, input int data);
    wait_ready("coef");
    bus.i_coef_we   = 1'b1;
    bus.i_coef_addr = NB_ADDR'(addr);
    bus.i_coef_data = NB_COEF'(data);
    @(posedge clock);
    #1 bus.i_coef_we = 1'b0;
  endtask

  task automatic load_coefs(input int c0, input int c1, input int c2, input int c3);
    write_coef(0, c0);
    write_coef(1, c1);
    write_coef(2, c2);
    write_coef(3, c3);
  endtask

  task automatic accept(input int s, input bit frame, output int acc_cyc);
    wait_ready("accept");
    bus.i_sample = NB_DATA'(s);
    bus.i_frame  = frame;
    bus.i_valid  = 1'b1;
    @(posedge clock);
    #1;
    acc_cyc     = cyc;
    bus.i_valid = 1'b0;
    bus.i_frame = 1'b0;
  endtask

  task automatic wait_output(input string tag, output int d, output int ch, output int oc);
    int n = 0;
    while (q_data.size() == 0 && n < 40) begin
      @(posedge clock);
      #1;
      n++;
    end
    if (q_data.size() == 0) begin
      check({tag, "_out_timeout"}, 0, 1);
      d = -999; ch = -1; oc = -1;
    end else begin
      d  = q_data.pop_front();
      ch = q_ch.pop_front();
      oc = q_cyc.pop_front();
    end
  endtask

  // Latency counts cycles from the accept cycle T to the o_valid cycle.
  task automatic send_check(input string tag, input int s, input bit frame,
                            input int exp_d, input int exp_ch);
    int a, d, ch, oc;
    accept(s, frame, a);
    wait_output(tag, d, ch, oc);
    check({tag, "_data"}, d, exp_d);
    check({tag, "_chan"}, ch, exp_ch);
    check({tag, "_lat"}, oc - a + 1, 5);
  endtask

  int imp_s  [8] = '{100, 0, 0, 0, 0, 0, 0, 0};
  bit imp_f  [8] = '{1, 0, 0, 0, 0, 0, 0, 0};
  int imp_d  [8] = '{50, 0, 25, 0, 12, 0, 6, 0};
  int imp_c  [8] = '{0, 1, 0, 1, 0, 1, 0, 1};

  int str_s  [6] = '{8, -16, 0, 0, 2, 0};
  bit str_f  [6] = '{1, 0, 0, 1, 0, 0};
  int str_d  [6] = '{29, -8, 14, 7, -3, 0};
  int str_c  [6] = '{0, 1, 0, 0, 1, 0};

  initial begin
    int a, d, ch, oc, n;
    int acc_t [6];

    bus.i_sample    = '0;
    bus.i_valid     = 1'b0;
    bus.i_frame     = 1'b0;
    bus.i_coef_we   = 1'b0;
    bus.i_coef_addr = '0;
    bus.i_coef_data = '0;

    // Reset
    i_reset = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    check("rst_valid", int'(bus.o_valid), 0);
    check("rst_data",  int'(bus.o_data), 0);
    check("rst_ready", int'(bus.o_ready), 1);
    check("rst_chan",  int'(bus.o_channel), 0);
    check("rst_drop",  int'(bus.o_coef_drop), 0);
    @(negedge clock);
    i_reset = 1'b1;

    // Impulse on ch0, zeros on ch1 interleaved
    load_coefs(64, 32, 16, 8);
    for (int i = 0; i < 8; i++)
      send_check($sformatf("imp%0d", i), imp_s[i], imp_f[i], imp_d[i], imp_c[i]);

    // Coefficient write while busy is dropped
    accept(100, 1'b1, a);
    @(posedge clock); #1;
    check("drop_busy", int'(bus.o_ready), 0);
    bus.i_coef_we   = 1'b1;
    bus.i_coef_addr = '0;
    bus.i_coef_data = NB_COEF'(127);
    @(posedge clock); #1;
    bus.i_coef_we = 1'b0;
    check("drop_pulse", int'(bus.o_coef_drop), 1);
    @(posedge clock); #1;
    check("drop_once", int'(bus.o_coef_drop), 0);
    wait_output("drop", d, ch, oc);
    check("drop_data", d, 50);
    check("drop_chan", ch, 0);
    send_check("drop_next", 100, 1'b0, 50, 1);

    // Overflow: four full-scale samples on ch0
    load_coefs(127, 127, 127, 127);
    for (int i = 0; i < 4; i++) begin
      accept(127, 1'b1, a);
      wait_output("ovf", d, ch, oc);
    end
    check("ovf_data", d, OVF_EXP);
    check("ovf_chan", ch, 0);

    // Asynchronous reset in the middle of a MAC
    accept(55, 1'b1, a);
    @(posedge clock); #1;
    i_reset = 1'b0;
    #1;
    check("mid_rst_ready", int'(bus.o_ready), 1);
    check("mid_rst_valid", int'(bus.o_valid), 0);
    check("mid_rst_data",  int'(bus.o_data), 0);
    repeat (3) @(posedge clock);
    @(negedge clock);
    i_reset = 1'b1;
    repeat (10) @(posedge clock);
    #1;
    check("mid_rst_no_out", q_data.size(), 0);
    load_coefs(64, 32, 16, 8);
    send_check("mid_rst_imp", 100, 1'b1, 50, 0);

    // Streaming with i_valid held high, frame realign at a3
    bus.i_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.i_sample = NB_DATA'(str_s[i]);
      bus.i_frame  = str_f[i];
      n = 0;
      while (bus.o_ready !== 1'b1 && n < 50) begin
        @(posedge clock); #1;
        n++;
      end
      if (n >= 50) check("stream_ready_timeout", 0, 1);
      @(posedge clock); #1;
      acc_t[i] = cyc;
      if (i > 0) check($sformatf("stream_gap%0d", i), acc_t[i] - acc_t[i-1], 5);
    end
    bus.i_valid = 1'b0;
    bus.i_frame = 1'b0;
    for (int i = 0; i < 6; i++) begin
      wait_output("stream", d, ch, oc);
      check($sformatf("stream%0d_data", i), d, str_d[i]);
      check($sformatf("stream%0d_chan", i), ch, str_c[i]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
